// File: rtl/elev_pkg.sv
// Shared types for the elevator controller, its car stage and benches.
package elev_pkg;

  typedef enum logic [1:0] {
    STOP       = 2'b00,
    DOWN_GOING = 2'b10,
    UP_GOING   = 2'b11
  } move_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SETTLE,
    DOOR
  } ctrl_st_t;

endpackage

// File: rtl/elev_req_scan.sv
// Combinational request scan: is there a call here, above or below the car.
module elev_req_scan #(
  parameter int NUM_FLOORS = 5,
  parameter int FLOOR_W    = 5
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor_cur,
  output logic                  here,
  output logic                  above,
  output logic                  below
);

  localparam logic [NUM_FLOORS-1:0] ALL_ONES = '1;
  localparam logic [NUM_FLOORS-1:0] BIT0     = NUM_FLOORS'(1);

  logic [NUM_FLOORS-1:0] here_mask;
  logic [NUM_FLOORS-1:0] at_or_above;
  logic [NUM_FLOORS-1:0] above_mask;
  logic [NUM_FLOORS-1:0] below_mask;

  // Shifts saturate to zero for out-of-range floors, so masks never wrap.
  always_comb begin
    here_mask   = BIT0 << floor_cur;
    at_or_above = ALL_ONES << floor_cur;
    above_mask  = at_or_above << 1;
    below_mask  = ~at_or_above;
    here        = |(pending & here_mask);
    above       = |(pending & above_mask);
    below       = |(pending & below_mask);
  end

endmodule

// File: rtl/elev_controller.sv
// Collective (SCAN) elevator scheduler: latches calls, picks direction and
// issues one-floor move pulses to the car stage, with door dwell handling.
module elev_controller
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS    = 5,
  parameter int FLOOR_W       = 5,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DWELL_CYCLES  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    floor_cur,
  output logic [1:0]            state,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  dir_up,
  output logic                  fault
);

  localparam int TMR_MAX = (DWELL_CYCLES > TRAVEL_CYCLES) ? DWELL_CYCLES : TRAVEL_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0]      TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0]      DWELL_LOAD  = TMR_W'(DWELL_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]    TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] BIT0        = NUM_FLOORS'(1);

  ctrl_st_t              st_q, st_d;
  move_cmd_t             cmd_q, cmd_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic                  dir_q, dir_d;
  logic                  fault_q, fault_d;
  logic [TMR_W-1:0]      timer_q, timer_d;

  logic                  here, above, below;
  logic [NUM_FLOORS-1:0] floor_bit;
  logic                  at_top, at_bottom, bad_floor;
  logic                  clr_here;
  logic                  want_move, want_up;

  elev_req_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_scan (
    .pending   (pend_q),
    .floor_cur (floor_cur),
    .here      (here),
    .above     (above),
    .below     (below)
  );

  always_comb begin
    floor_bit = BIT0 << floor_cur;
    at_top    = (floor_cur == TOP_FLOOR);
    at_bottom = (floor_cur == '0);
    bad_floor = (floor_cur > TOP_FLOOR);
  end

  always_comb begin
    st_d      = st_q;
    cmd_d     = STOP;
    dir_d     = dir_q;
    fault_d   = fault_q;
    timer_d   = timer_q;
    clr_here  = 1'b0;
    want_move = 1'b0;
    want_up   = dir_q;
    pend_d    = pend_q | call_btn;

    if (fault_q || bad_floor) begin
      fault_d = 1'b1;
      st_d    = IDLE;
      timer_d = '0;
      pend_d  = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (here) begin
            st_d     = DOOR;
            timer_d  = DWELL_LOAD;
            clr_here = 1'b1;
          end else if (above && (dir_q || !below)) begin
            want_move = 1'b1;
            want_up   = 1'b1;
          end else if (below) begin
            want_move = 1'b1;
            want_up   = 1'b0;
          end
        end
        MOVE: begin
          st_d    = SETTLE;
          timer_d = TRAVEL_LOAD;
        end
        SETTLE: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TMR_W'(1);
          end else if (here) begin
            st_d     = DOOR;
            timer_d  = DWELL_LOAD;
            clr_here = 1'b1;
          end else if (dir_q ? above : below) begin
            want_move = 1'b1;
            want_up   = dir_q;
          end else if (dir_q ? below : above) begin
            want_move = 1'b1;
            want_up   = !dir_q;
          end else begin
            st_d = IDLE;
          end
        end
        DOOR: begin
          // A call at the open floor is absorbed and restarts the dwell.
          clr_here = 1'b1;
          if (|(call_btn & floor_bit)) begin
            timer_d = DWELL_LOAD;
          end else if (timer_q == '0) begin
            st_d = IDLE;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
        default: st_d = IDLE;
      endcase

      // A move past either end can only come from corrupt scan data: park instead.
      if (want_move) begin
        if (want_up ? at_top : at_bottom) begin
          st_d = IDLE;
        end else begin
          st_d  = MOVE;
          dir_d = want_up;
          cmd_d = want_up ? UP_GOING : DOWN_GOING;
        end
      end

      if (clr_here) begin
        pend_d = pend_d & ~floor_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      cmd_q   <= STOP;
      pend_q  <= '0;
      dir_q   <= 1'b1;
      fault_q <= 1'b0;
      timer_q <= '0;
    end else begin
      st_q    <= st_d;
      cmd_q   <= cmd_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      fault_q <= fault_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state     = cmd_q;
    pending   = pend_q;
    door_open = (st_q == DOOR);
    dir_up    = dir_q;
    fault     = fault_q;
  end

endmodule

// File: tb/tb_elev_controller.sv
// Closed-loop bench: a simple car plant follows the move pulses while a
// reference scheduler model and hand-written sequences check the controller.
module tb_elev_controller;
  import elev_pkg::*;

  localparam int N  = 5;
  localparam int FW = 5;
  localparam int TC = 4;
  localparam int DC = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  call_btn;
  logic [FW-1:0] floor_cur;
  logic [1:0]    state;
  logic [N-1:0]  pending;
  logic          door_open, dir_up, fault;

  always #5 clk = ~clk;

  elev_controller #(
    .NUM_FLOORS    (N),
    .FLOOR_W       (FW),
    .TRAVEL_CYCLES (TC),
    .DWELL_CYCLES  (DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .call_btn  (call_btn),
    .floor_cur (floor_cur),
    .state     (state),
    .pending   (pending),
    .door_open (door_open),
    .dir_up    (dir_up),
    .fault     (fault)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // plant and observation state
  int         pos      = 0;
  int         force_fl = -1;
  bit         prev_door = 1'b0;
  logic [1:0] first_cmd;
  int         door_floors[$];

  // reference model state
  ctrl_st_t   m_ph;
  bit         m_pend[N];
  bit         m_dir;
  bit         m_fault;
  int         m_timer;
  logic [1:0] m_cmd;

  typedef struct {
    logic [N-1:0] btn;
    logic [1:0]   st;
    logic         door;
    logic [N-1:0] pend;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t floor=%0d)", nm, act, exp, $time, pos);
    end
  endtask

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic void model_reset();
    m_ph = IDLE; m_dir = 1'b1; m_fault = 1'b0; m_timer = 0; m_cmd = STOP;
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
  endfunction

  function automatic void model_open(input int fl);
    m_ph = DOOR; m_timer = DC - 1; m_pend[fl] = 1'b0;
  endfunction

  // One clock of scheduler behaviour, written from the direction rules.
  function automatic void model_step(input bit r, input logic [N-1:0] btn, input int fl);
    bit req_here, req_up, req_dn;
    int go;
    if (r) begin model_reset(); return; end
    m_cmd = STOP;
    if (m_fault || fl >= N) begin
      m_fault = 1'b1; m_ph = IDLE; m_timer = 0;
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      return;
    end
    req_here = m_pend[fl]; req_up = 1'b0; req_dn = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && i > fl) req_up = 1'b1;
      if (m_pend[i] && i < fl) req_dn = 1'b1;
    end
    for (int i = 0; i < N; i++) if (btn[i]) m_pend[i] = 1'b1;
    go = -1;
    case (m_ph)
      IDLE: begin
        if (req_here) model_open(fl);
        else if (req_up && (m_dir || !req_dn)) go = 1;
        else if (req_dn) go = 0;
      end
      MOVE: begin m_ph = SETTLE; m_timer = TC - 1; end
      SETTLE: begin
        if (m_timer > 0) m_timer--;
        else if (req_here) model_open(fl);
        else if (m_dir ? req_up : req_dn) go = m_dir ? 1 : 0;
        else if (m_dir ? req_dn : req_up) go = m_dir ? 0 : 1;
        else m_ph = IDLE;
      end
      default: begin
        m_pend[fl] = 1'b0;
        if (btn[fl]) m_timer = DC - 1;
        else if (m_timer == 0) m_ph = IDLE;
        else m_timer--;
      end
    endcase
    if (go >= 0) begin
      if ((go == 1 && fl == N - 1) || (go == 0 && fl == 0)) m_ph = IDLE;
      else begin
        m_ph = MOVE; m_dir = (go == 1);
        m_cmd = (go == 1) ? UP_GOING : DOWN_GOING;
      end
    end
  endfunction

  task automatic step(input bit r, input logic [N-1:0] btn);
    logic [1:0] cmd_before;
    int fl;
    fl = (force_fl >= 0) ? force_fl : pos;
    rst = r; call_btn = btn; floor_cur = FW'(fl);
    cmd_before = state;
    model_step(r, btn, fl);
    @(posedge clk); #1;
    if (force_fl < 0) begin
      if (cmd_before == UP_GOING) pos++;
      else if (cmd_before == DOWN_GOING) pos--;
    end
    chk("state", 32'(state), 32'(m_cmd));
    chk("pending", 32'(pending), 32'(m_pend_vec()));
    chk("door_open", 32'(door_open), 32'(m_ph == DOOR));
    chk("dir_up", 32'(dir_up), 32'(m_dir));
    chk("fault", 32'(fault), 32'(m_fault));
    n_cmp++;
    if ((state == UP_GOING && pos == N - 1) || (state == DOWN_GOING && pos == 0)) begin
      n_bad++;
      $display("FAIL bounds: got move %0b at floor %0d required no move past end", state, pos);
    end
    if (state != STOP && first_cmd == STOP) first_cmd = state;
    if (door_open && !prev_door) door_floors.push_back(pos);
    prev_door = door_open;
  endtask

  task automatic do_reset(input int at_floor);
    pos = at_floor; force_fl = -1;
    step(1'b1, '0);
    door_floors.delete();
    first_cmd = STOP;
  endtask

  task automatic run_idle(input string nm, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      step(1'b0, '0);
      if (pending == '0 && !door_open && state == STOP) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s: got busy after %0d cycles required idle", nm, budget);
    end
  endtask

  function automatic void add(input logic [N-1:0] b, input logic [1:0] s,
                              input logic d, input logic [N-1:0] p);
    vec_t v;
    v.btn = b; v.st = s; v.door = d; v.pend = p;
    vt.push_back(v);
  endfunction

  initial begin
    int cnt;
    rst = 1'b1; call_btn = '0; floor_cur = '0;
    first_cmd = STOP;

    // reset values
    do_reset(0);
    step(1'b1, '0);
    chk("rst_state", 32'(state), 32'(STOP));
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_door", 32'(door_open), 32'h0);
    chk("rst_dir", 32'(dir_up), 32'h1);
    chk("rst_fault", 32'(fault), 32'h0);

    // floor 0, pulse call 3: three UP pulses, settles, then a 10-cycle door
    add(5'b01000, STOP, 1'b0, 5'b01000);
    for (int m = 0; m < 3; m++) begin
      add('0, UP_GOING, 1'b0, 5'b01000);
      for (int s = 0; s < TC; s++) add('0, STOP, 1'b0, (m == 2 && s == TC) ? '0 : 5'b01000);
    end
    for (int d = 0; d < DC; d++) add('0, STOP, 1'b1, '0);
    add('0, STOP, 1'b0, '0);
    for (int i = 0; i < vt.size(); i++) begin
      step(1'b0, vt[i].btn);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].st));
      chk($sformatf("vec%0d_door", i), 32'(door_open), 32'(vt[i].door));
      chk($sformatf("vec%0d_pend", i), 32'(pending), 32'(vt[i].pend));
    end
    chk("vec_floor", 32'(pos), 32'd3);

    // idle at 2 going up, press 4 and 0 together: 4 first, then reverse
    do_reset(0);
    step(1'b0, 5'b00100);
    run_idle("reach2", 100);
    chk("at2_dir", 32'(dir_up), 32'h1);
    door_floors.delete(); first_cmd = STOP;
    step(1'b0, 5'b10001);
    run_idle("tie_idle", 200);
    chk("tie_first_move", 32'(first_cmd), 32'(UP_GOING));
    chk("tie_doors", 32'(door_floors.size()), 32'd2);
    if (door_floors.size() == 2) begin
      chk("tie_door0", 32'(door_floors[0]), 32'd4);
      chk("tie_door1", 32'(door_floors[1]), 32'd0);
    end

    // moving up 1 -> 4, call 3 while settling at 2
    do_reset(1);
    step(1'b0, 5'b10000);
    for (int k = 0; k < 30 && pos != 2; k++) step(1'b0, '0);
    chk("reach_floor2", 32'(pos), 32'd2);
    step(1'b0, 5'b01000);
    run_idle("insert_idle", 200);
    chk("insert_doors", 32'(door_floors.size()), 32'd2);
    if (door_floors.size() == 2) begin
      chk("insert_door0", 32'(door_floors[0]), 32'd3);
      chk("insert_door1", 32'(door_floors[1]), 32'd4);
    end

    // re-press at dwell count 3 restarts the dwell: 7 + 10 open cycles
    do_reset(2);
    step(1'b0, 5'b00100);
    for (int k = 0; k < 10 && !door_open; k++) step(1'b0, '0);
    chk("dwell_open", 32'(door_open), 32'h1);
    cnt = 1;
    for (int k = 0; k < 40 && door_open; k++) begin
      step(1'b0, (cnt == 7) ? 5'b00100 : 5'b00000);
      if (door_open) cnt++;
    end
    chk("dwell_total", 32'(cnt), 32'd17);

    // out-of-range floor: sticky fault until reset
    do_reset(0);
    step(1'b0, 5'b01000);
    step(1'b0, '0);
    force_fl = 7;
    step(1'b0, 5'b00010);
    chk("fault_set", 32'(fault), 32'h1);
    chk("fault_state", 32'(state), 32'(STOP));
    chk("fault_pend", 32'(pending), 32'h0);
    force_fl = -1;
    pos = 2;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 5'b11111);
      chk("fault_hold", 32'({fault, state, pending}), 32'({1'b1, 2'b00, 5'b00000}));
    end
    step(1'b1, '0);
    chk("fault_clr", 32'({fault, dir_up, door_open, state, pending}), 32'({3'b010, 2'b00, 5'b00000}));

    // reset during a move pulse
    do_reset(0);
    step(1'b0, 5'b00100);
    for (int k = 0; k < 10 && state != UP_GOING; k++) step(1'b0, '0);
    chk("mid_move_up", 32'(state), 32'(UP_GOING));
    step(1'b1, '0);
    chk("mid_move_rst", 32'({state, pending, dir_up}), 32'({2'b00, 5'b00000, 1'b1}));

    // randomized closed-loop traffic
    do_reset(0);
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] b;
      b = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      step(($urandom_range(0, 599) == 0), b);
    end
    run_idle("random_drain", 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
